ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_host_tx_if.sv | 41 ++++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - state encoding, frame constants and timing defaults for the PS/2 host transmitter
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_START   = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_EDGES = 11;
    localparam int unsigned PS2_STOP_EDGE   = PS2_FRAME_EDGES - 1;

    localparam int unsigned PS2_DEFAULT_CLK_FREQ_HZ = 50_000_000;
    localparam int unsigned PS2_DEFAULT_INHIBIT     = 6000;
    localparam int unsigned PS2_DEFAULT_TIMEOUT     = 750_000;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake and open-drain PS/2 line bundle
interface ps2_host_tx_if;

    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        input  cmd_data,
        input  cmd_valid,
        input  ps2_clk_in,
        input  ps2_data_in,
        output cmd_ready,
        output ps2_clk_oe,
        output ps2_data_oe,
        output done,
        output ack_err,
        output timeout_err
    );

    modport slave (
        output cmd_data,
        output cmd_valid,
        output ps2_clk_in,
        output ps2_data_in,
        input  cmd_ready,
        input  ps2_clk_oe,
        input  ps2_data_oe,
        input  done,
        input  ack_err,
        input  timeout_err
    );

endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - two-flop synchronizer plus falling-edge detect for one PS/2 line
module ps2_line_sync (
    input  logic clk,
    input  logic clrn,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle PS/2 lines are pulled high, so all stages reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter; PS2_TX_TIMEOUT_EN adds a frame watchdog
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = PS2_DEFAULT_CLK_FREQ_HZ,
    parameter int unsigned INHIBIT_CYCLES = PS2_DEFAULT_INHIBIT,
    parameter int unsigned TIMEOUT_CYCLES = PS2_DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          clrn,
    ps2_host_tx_if.master bus
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                         : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [3:0]       STOP_EDGE = 4'(PS2_STOP_EDGE);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    // Our own clock pull-down produces a synchronized falling edge ~3 cycles later;
    // the inhibit window must swallow it before START starts listening.
    if (CLK_FREQ_HZ == 0 || INHIBIT_CYCLES < 4) begin : g_param_check
        $error("ps2_host_tx: CLK_FREQ_HZ must be nonzero and INHIBIT_CYCLES at least 4");
    end

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       edge_q, edge_d;
    logic [8:0]       shift_q, shift_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
`ifdef PS2_TX_TIMEOUT_EN
    logic             timeout_q, timeout_d;
`endif

    logic clk_sync, clk_fall;
    logic data_sync, data_fall;
    logic unused_data_fall;

    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .clrn   (clrn),
        .line_i (bus.ps2_clk_in),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk    (clk),
        .clrn   (clrn),
        .line_i (bus.ps2_data_in),
        .sync_o (data_sync),
        .fall_o (data_fall)
    );

    assign unused_data_fall = data_fall;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            shift_q   <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            shift_q   <= shift_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
`ifdef PS2_TX_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        shift_d   = shift_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        timeout_d = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                edge_d    = '0;
                data_oe_d = 1'b0;
                if (bus.cmd_valid) begin
                    shift_d = {1'b0, bus.cmd_data};
                    state_d = ST_INHIBIT;
                end
            end

            // Parity is folded in above the byte once it is stable, so edges 1..10 are one shift.
            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d      = '0;
                    shift_d[8] = odd_parity(shift_q[7:0]);
                    data_oe_d  = 1'b1;
                    state_d    = ST_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Ones shift in from the top, so the tenth edge naturally releases data (stop bit).
            ST_START, ST_SHIFT: begin
                if (clk_fall) begin
                    edge_d    = edge_q + 4'd1;
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[8:1]};
                    state_d   = (edge_d == STOP_EDGE) ? ST_ACK : ST_SHIFT;
                end
            end

            ST_ACK: begin
                if (clk_fall) begin
                    edge_d = edge_q + 4'd1;
                    if (!data_sync) begin
                        done_d = 1'b1;
                    end else begin
                        ack_err_d = 1'b1;
                    end
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                data_oe_d = 1'b0;
                if (clk_sync && data_sync) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // A real ACK on the expiry cycle wins, keeping a single outcome pulse per command.
        if ((state_q inside {ST_START, ST_SHIFT, ST_ACK}) && (state_d != ST_RELEASE)) begin
            if (cnt_q == TO_LAST) begin
                data_oe_d = 1'b0;
                timeout_d = 1'b1;
                state_d   = ST_RELEASE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.ps2_clk_oe  = (state_q == ST_INHIBIT);
    assign bus.ps2_data_oe = data_oe_q | ((state_q == ST_INHIBIT) && (cnt_q == INH_LAST));
    assign bus.done        = done_q;
    assign bus.ack_err     = ack_err_q;
`ifdef PS2_TX_TIMEOUT_EN
    assign bus.timeout_err = timeout_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - table-driven bench with a PS/2 device model and frame scoreboard
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int HALF       = 20;
    localparam int TB_INHIBIT = 6000;
    localparam int TB_TIMEOUT = 1000;

    logic clk = 1'b0;
    logic clrn;
    logic dev_clk;
    logic dev_data;

    ps2_host_tx_if bus ();

    assign bus.ps2_clk_in  = dev_clk  & ~bus.ps2_clk_oe;
    assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ    (50_000_000),
        .INHIBIT_CYCLES (TB_INHIBIT),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int done_cnt   = 0;
    int ackerr_cnt = 0;
    int to_cnt     = 0;

    always @(negedge clk) begin
        if (bus.done === 1'b1)        done_cnt   <= done_cnt + 1;
        if (bus.ack_err === 1'b1)     ackerr_cnt <= ackerr_cnt + 1;
        if (bus.timeout_err === 1'b1) to_cnt     <= to_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       parity;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        logic       ack_low;
        logic       exp_done;
        logic       exp_err;
        logic       exp_par;
    } vec_t;

    frame_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] d);
        @(negedge clk);
        check("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        bus.cmd_data  = d;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        check("cmd_ready_busy", 32'(bus.cmd_ready), 0);
    endtask

    // Leaves the bench on the first sample after the inhibit window closes.
    task automatic check_inhibit();
        int   len    = 0;
        int   dat_hi = 0;
        logic last   = 1'b0;
        while (bus.ps2_clk_oe === 1'b1 && len < 20000) begin
            len++;
            if (bus.ps2_data_oe === 1'b1) dat_hi++;
            last = bus.ps2_data_oe;
            @(negedge clk);
        end
        check("inhibit_len", 32'(len), TB_INHIBIT);
        check("start_on_last_inhibit", 32'({dat_hi == 1, last}), 32'b11);
        check("start_bit_held", 32'(bus.ps2_data_oe), 1);
    endtask

    task automatic device_frame(input logic ack_low, input int abort_edge, output logic [9:0] bits);
        bits = '0;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) dev_data = ~ack_low;
            cycles(HALF);
            dev_clk = 1'b0;
            if (i == abort_edge) return;
            cycles(HALF);
            dev_clk = 1'b1;
            if (i <= 10) bits[i-1] = bus.ps2_data_in;
            if (i == 11) dev_data = 1'b1;
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.cmd_ready), 1);
    endtask

    task automatic compare_frame(input logic [9:0] bits);
        frame_t exp;
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
            return;
        end
        exp = sb_q.pop_front();
        check("frame_data", 32'(bits[7:0]), 32'(exp.data));
        check("frame_parity", 32'(bits[8]), 32'(exp.parity));
        check("frame_stop", 32'(bits[9]), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int d0 = done_cnt;
        int a0 = ackerr_cnt;
        int t0 = to_cnt;
        logic [9:0] bits;
        sb_q.push_back('{v.data, v.exp_par});
        send_cmd(v.data);
        check_inhibit();
        cycles(10);
        device_frame(v.ack_low, 0, bits);
        wait_ready("ready_after_frame");
        compare_frame(bits);
        check("done_pulses", 32'(done_cnt - d0), 32'(v.exp_done));
        check("ack_err_pulses", 32'(ackerr_cnt - a0), 32'(v.exp_err));
        check("timeout_pulses", 32'(to_cnt - t0), 0);
    endtask

    vec_t       vecs[5];
    logic [9:0] fbits;
    int         d0, a0, t0, n, hi;

    initial begin
        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'hF4, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hA7, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1};

        clrn          = 1'b0;
        dev_clk       = 1'b1;
        dev_data      = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        cycles(3);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_oes", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 0);
        check("rst_pulses", 32'({bus.done, bus.ack_err, bus.timeout_err}), 0);
        clrn = 1'b1;
        cycles(3);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            cycles(5);
        end

        // A command offered mid-transfer must leave no trace on the bus.
        d0 = done_cnt;
        sb_q.push_back('{8'hED, 1'b1});
        send_cmd(8'hED);
        check_inhibit();
        fork
            begin
                cycles(10);
                device_frame(1'b1, 0, fbits);
            end
            begin
                cycles(100);
                bus.cmd_data  = 8'h00;
                bus.cmd_valid = 1'b1;
                cycles(3);
                bus.cmd_valid = 1'b0;
            end
        join
        wait_ready("ready_after_busy_cmd");
        compare_frame(fbits);
        check("busy_cmd_done_once", 32'(done_cnt - d0), 1);
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.ps2_clk_oe === 1'b1) hi++;
        end
        check("busy_cmd_not_queued", 32'(hi), 0);

        // Reset after edge 5 while the host is pulling data low for bit 4 of 0xED.
        d0 = done_cnt;
        a0 = ackerr_cnt;
        send_cmd(8'hED);
        check_inhibit();
        cycles(10);
        device_frame(1'b1, 5, fbits);
        cycles(6);
        check("abort_data_oe_before", 32'(bus.ps2_data_oe), 1);
        #2 clrn = 1'b0;
        #1;
        check("abort_oes_cleared", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 0);
        check("abort_cmd_ready", 32'(bus.cmd_ready), 1);
        @(negedge clk);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        cycles(2);
        clrn = 1'b1;
        cycles(5);
        check("abort_no_outcome", 32'((done_cnt - d0) + (ackerr_cnt - a0)), 0);
        run_vec('{8'h55, 1'b1, 1'b1, 1'b0, 1'b1});
        cycles(5);

        // Device never clocks.
        t0 = to_cnt;
        d0 = done_cnt;
        send_cmd(8'h3C);
        check_inhibit();
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
`ifdef PS2_TX_TIMEOUT_EN
        check("timeout_cycle", 32'(n), TB_TIMEOUT);
        check("timeout_oes", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 0);
        wait_ready("ready_after_timeout");
        check("timeout_pulse_once", 32'(to_cnt - t0), 1);
        check("timeout_no_done", 32'(done_cnt - d0), 0);
`else
        check("no_watchdog_pulse", 32'(n), 3000);
        check("no_watchdog_still_waiting", 32'({bus.ps2_data_oe, bus.cmd_ready}), 32'b10);
        check("no_watchdog_count", 32'(to_cnt - t0), 0);
        #2 clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        wait_ready("ready_after_reset");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
